// File: rtl/rv_instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded field bundles into 32-bit
// instruction words with sequential word addresses for memory-image building.
module rv_instr_encoder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_format,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instruction,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_illegal,
   output logic              out_done,
   output logic              out_wrap,
   output logic [7:0]        out_err_count
);
   localparam int unsigned ILEN  = 32;
   localparam int unsigned ERR_W = 8;
   localparam logic [ILEN-1:0]  NOP_WORD = 32'h0000_0013;
   localparam logic [6:0]       OP_IMM   = 7'b0010011;
   localparam logic [ERR_W-1:0] ERR_MAX  = 8'hFF;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_e;

   state_e              state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [ILEN-1:0]     instr_q, instr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                illegal_q, illegal_d;
   logic                done_q, done_d;
   logic                wrap_q, wrap_d;
   logic [ERR_W-1:0]    err_q, err_d;

   logic                accept;
   logic                out_hs;
   logic                is_shift;
   logic [ILEN-1:0]     enc_word;
   logic                enc_illegal;

   assign in_ready = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   // Field packing; unencodable bundles are flagged and replaced by addi x0,x0,0.
   always_comb begin
      enc_word    = NOP_WORD;
      enc_illegal = 1'b0;
      is_shift    = (in_opcode == OP_IMM) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
      case (in_format)
         FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: begin
            if (is_shift) begin
               enc_word    = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
               enc_illegal = |in_imm[31:5];
            end else begin
               enc_word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
               enc_illegal = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
            end
         end
         FMT_S: begin
            enc_word    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_illegal = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
         end
         FMT_B: begin
            enc_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            enc_illegal = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
         end
         FMT_U: begin
            enc_word    = {in_imm[31:12], in_rd, in_opcode};
            enc_illegal = |in_imm[11:0];
         end
         FMT_J: begin
            enc_word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_illegal = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
         end
         default: enc_illegal = 1'b1;
      endcase
      if (enc_illegal) begin
         enc_word = NOP_WORD;
      end
   end

   // Burst sequencing, output register and address/error bookkeeping.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      addr_d      = addr_q;
      illegal_d   = illegal_q;
      done_d      = 1'b0;
      wrap_d      = wrap_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               addr_d  = ADDR_W'(BASE_ADDR);
               wrap_d  = 1'b0;
               err_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (accept && in_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_hs) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (out_hs) begin
         out_valid_d = 1'b0;
         addr_d      = addr_q + ADDR_W'(1);
         if (&addr_q) begin
            wrap_d = 1'b1;
         end
      end

      // A new accept in the same cycle as a handshake refills the register.
      if (accept) begin
         out_valid_d = 1'b1;
         instr_d     = enc_word;
         illegal_d   = enc_illegal;
         if (enc_illegal && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         addr_q      <= '0;
         illegal_q   <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         addr_q      <= addr_d;
         illegal_q   <= illegal_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_instruction = instr_q;
   assign out_addr        = addr_q;
   assign out_illegal     = illegal_q;
   assign out_done        = done_q;
   assign out_wrap        = wrap_q;
   assign out_err_count   = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: default instance plus a 2-bit-address
// instance (BASE_ADDR=3) sharing the same stimulus.
module tb_rv_instr_encoder;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_start, in_valid, in_last, out_ready;
   logic [2:0]  in_format, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;

   logic        in_ready0, out_valid0, out_ill0, out_done0, out_wrap0;
   logic [31:0] out_instr0;
   logic [9:0]  out_addr0;
   logic [7:0]  out_err0;
   logic        in_ready1, out_valid1, out_ill1, out_done1, out_wrap1;
   logic [31:0] out_instr1;
   logic [1:0]  out_addr1;
   logic [7:0]  out_err1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_addr = 0;

   logic [31:0] exp_instr_q[$];
   logic        exp_ill_q[$];
   logic [31:0] got_instr_q[$];
   logic [31:0] got_addr_q[$];
   logic        got_ill_q[$];
   int          got_cyc_q[$];
   logic [31:0] got_addr1_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv_instr_encoder dut0 (
      .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_valid(in_valid),
      .in_ready(in_ready0), .in_last(in_last), .in_format(in_format),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid0), .out_ready(out_ready), .out_instruction(out_instr0),
      .out_addr(out_addr0), .out_illegal(out_ill0), .out_done(out_done0),
      .out_wrap(out_wrap0), .out_err_count(out_err0)
   );

   rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_valid(in_valid),
      .in_ready(in_ready1), .in_last(in_last), .in_format(in_format),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid1), .out_ready(out_ready), .out_instruction(out_instr1),
      .out_addr(out_addr1), .out_illegal(out_ill1), .out_done(out_done1),
      .out_wrap(out_wrap1), .out_err_count(out_err1)
   );

   // Record every output handshake, sampled half a cycle before its edge.
   always @(negedge clk) begin
      if (rst_n && out_valid0 && out_ready) begin
         got_instr_q.push_back(out_instr0);
         got_addr_q.push_back(32'(out_addr0));
         got_ill_q.push_back(out_ill0);
         got_cyc_q.push_back(cyc);
      end
      if (rst_n && out_valid1 && out_ready) begin
         got_addr1_q.push_back(32'(out_addr1));
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_w, input logic exp_il);
      in_format = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
      exp_instr_q.push_back(exp_w);
      exp_ill_q.push_back(exp_il);
   endtask

   // Present one bundle and return one tick after the edge that accepts it.
   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic last,
                       input logic [31:0] exp_w, input logic exp_il);
      logic acc;
      acc = 1'b0;
      drive(fmt, op, rd, rs1, rs2, f3, f7, imm, last, exp_w, exp_il);
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready0;
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic sb_flush();
      while (exp_instr_q.size() > 0) begin
         if (got_instr_q.size() == 0) begin
            check_eq("sb_missing", 32'(exp_instr_q.size()), 32'd0);
            exp_instr_q.delete();
            exp_ill_q.delete();
         end else begin
            check_eq("instr", got_instr_q.pop_front(), exp_instr_q.pop_front());
            check_eq("addr", got_addr_q.pop_front(), 32'(exp_addr));
            check_eq("illegal", 32'(got_ill_q.pop_front()), 32'(exp_ill_q.pop_front()));
            exp_addr++;
         end
      end
      check_eq("sb_extra", 32'(got_instr_q.size()), 32'd0);
      got_instr_q.delete();
      got_addr_q.delete();
      got_ill_q.delete();
      got_cyc_q.delete();
   endtask

   task automatic pulse_start();
      in_start = 1'b1;
      @(posedge clk);
      #1;
      in_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_format = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid0), 32'd0);
      check_eq("rst_ready", 32'(in_ready0), 32'd0);
      check_eq("rst_instr", out_instr0, 32'd0);
      check_eq("rst_addr", 32'(out_addr0), 32'd0);
      check_eq("rst_addr1", 32'(out_addr1), 32'd0);
      check_eq("rst_err", 32'(out_err0), 32'd0);
      check_eq("rst_flags1", {28'd0, out_valid1, out_ill1, out_done1, out_wrap1}, 32'd0);
      check_eq("rst_instr1", out_instr1, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Plan 1-3: legal formats then illegal bundles
      pulse_start();
      check_eq("start_ready", 32'(in_ready0), 32'd1);
      check_eq("start_addr1", 32'(out_addr1), 32'd3);
      exp_addr = 0;
      send(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          1'b0, 32'h002081B3, 1'b0);
      send(3'd1, 7'h13, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF,   1'b0, 32'hFFF00293, 1'b0);
      send(3'd2, 7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          1'b0, 32'h0020A423, 1'b0);
      send(3'd3, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC,   1'b0, 32'hFE000EE3, 1'b0);
      send(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       1'b0, 32'h001000EF, 1'b0);
      send(3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,   1'b0, 32'h12345537, 1'b0);
      send(3'd1, 7'h13, 5'd1,  5'd1, 5'd0, 3'd5, 7'h20, 32'd3,          1'b0, 32'h4030D093, 1'b0);
      send(3'd1, 7'h13, 5'd1,  5'd1, 5'd0, 3'd1, 7'h00, 32'd3,          1'b0, 32'h00309093, 1'b0);
      send(3'd3, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'd3,          1'b0, NOP,          1'b1);
      send(3'd1, 7'h13, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,       1'b0, NOP,          1'b1);
      send(3'd6, 7'h33, 5'd1,  5'd1, 5'd1, 3'd0, 7'h00, 32'd0,          1'b0, NOP,          1'b1);
      repeat (2) @(posedge clk);
      #1;
      sb_flush();
      check_eq("err_count", 32'(out_err0), 32'd3);
      check_eq("err_count1", 32'(out_err1), 32'd3);
      check_eq("addr_after", 32'(out_addr0), 32'd11);

      // Plan 6b: in_start mid-stream is ignored
      pulse_start();
      check_eq("ign_start_err", 32'(out_err0), 32'd3);
      check_eq("ign_start_addr", 32'(out_addr0), 32'd11);
      check_eq("ign_start_ready", 32'(in_ready0), 32'd1);

      // Plan 4: backpressure then full throughput
      out_ready = 1'b0;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 1'b0, 32'h00100093, 1'b0);
      @(posedge clk);
      #1;
      drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 1'b0, 32'h00200113, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_valid", 32'(out_valid0), 32'd1);
         check_eq("bp_ready", 32'(in_ready0), 32'd0);
         check_eq("bp_instr", out_instr0, 32'h00100093);
         check_eq("bp_addr", 32'(out_addr0), 32'd11);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 1'b0, 32'h00300193, 1'b0);
      @(posedge clk);
      #1;
      drive(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4, 1'b0, 32'h00400213, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("tput_count", 32'(got_cyc_q.size()), 32'd4);
      if (got_cyc_q.size() == 4) begin
         for (int i = 1; i < 4; i++) begin
            check_eq("tput_gap", 32'(got_cyc_q[i] - got_cyc_q[i-1]), 32'd1);
         end
      end
      sb_flush();

      // Close the burst: DRAIN, then out_done one cycle after the last handshake
      send(3'd0, 7'h33, 5'd7, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, 1'b1, 32'h406283B3, 1'b0);
      @(negedge clk);
      check_eq("drain_ready", 32'(in_ready0), 32'd0);
      check_eq("drain_valid", 32'(out_valid0), 32'd1);
      check_eq("drain_done_early", 32'(out_done0), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("done_pulse", 32'(out_done0), 32'd1);
      check_eq("idle_ready", 32'(in_ready0), 32'd0);
      @(negedge clk);
      check_eq("done_clear", 32'(out_done0), 32'd0);
      @(posedge clk);
      #1;
      sb_flush();

      // Plan 5: 2-bit address instance wraps 3 -> 0 -> 1
      got_addr1_q.delete();
      pulse_start();
      exp_addr = 0;
      check_eq("w_start_addr", 32'(out_addr1), 32'd3);
      check_eq("w_start_wrap", 32'(out_wrap1), 32'd0);
      check_eq("w_start_err", 32'(out_err1), 32'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 1'b0, 32'h00100093, 1'b0);
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 1'b0, 32'h00200113, 1'b0);
      send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 1'b1, 32'h00300193, 1'b0);
      @(negedge clk);
      check_eq("w_done_early", 32'(out_done1), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("w_done_pulse", 32'(out_done1), 32'd1);
      check_eq("w_idle_ready", 32'(in_ready1), 32'd0);
      @(negedge clk);
      check_eq("w_done_clear", 32'(out_done1), 32'd0);
      check_eq("w_wrap", 32'(out_wrap1), 32'd1);
      check_eq("w_nowrap0", 32'(out_wrap0), 32'd0);
      check_eq("w_count", 32'(got_addr1_q.size()), 32'd3);
      if (got_addr1_q.size() == 3) begin
         check_eq("w_addr0", got_addr1_q[0], 32'd3);
         check_eq("w_addr1", got_addr1_q[1], 32'd0);
         check_eq("w_addr2", got_addr1_q[2], 32'd1);
      end
      @(posedge clk);
      #1;
      sb_flush();

      // Plan 6a: reset while a word is pending in DRAIN
      pulse_start();
      out_ready = 1'b0;
      send(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0, 1'b1, NOP, 1'b1);
      @(negedge clk);
      check_eq("pre_rst_valid", 32'(out_valid0), 32'd1);
      check_eq("pre_rst_ill", 32'(out_ill0), 32'd1);
      check_eq("pre_rst_err", 32'(out_err0), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid0), 32'd0);
      check_eq("mid_rst_instr", out_instr0, 32'd0);
      check_eq("mid_rst_ill", 32'(out_ill0), 32'd0);
      check_eq("mid_rst_err", 32'(out_err0), 32'd0);
      check_eq("mid_rst_addr", 32'(out_addr0), 32'd0);
      check_eq("mid_rst_flags", {29'd0, out_done0, out_wrap0, in_ready0}, 32'd0);
      out_ready = 1'b1;
      exp_instr_q.delete();
      exp_ill_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("post_rst_done", 32'(out_done0), 32'd0);
         check_eq("post_rst_valid", 32'(out_valid0), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end
endmodule
